// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 3x4 keypad press generator.
//   - state_t    : controller states IDLE -> PRESS -> GAP -> IDLE
//   - PAT_<n>    : 7-bit line pattern per digit, bit order {g,f,e,d,c,b,a}
//                  (columns a,b,c in bits 2:0, rows d,e,f,g in bits 6:3)
//   - ERR_DIGIT  : highest legal digit; anything above it is rejected
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  //                                       gfedcba
  localparam logic [6:0] PAT_1 = 7'b0001001;  // a,d
  localparam logic [6:0] PAT_2 = 7'b0001010;  // b,d
  localparam logic [6:0] PAT_3 = 7'b0001100;  // c,d
  localparam logic [6:0] PAT_4 = 7'b0010001;  // a,e
  localparam logic [6:0] PAT_5 = 7'b0010010;  // b,e
  localparam logic [6:0] PAT_6 = 7'b0010100;  // c,e
  localparam logic [6:0] PAT_7 = 7'b0100001;  // a,f
  localparam logic [6:0] PAT_8 = 7'b0100010;  // b,f
  localparam logic [6:0] PAT_9 = 7'b0100100;  // c,f
  localparam logic [6:0] PAT_0 = 7'b1000010;  // b,g

  localparam logic [3:0] ERR_DIGIT = 4'd9;

endpackage

// File: rtl/keypad_pattern.sv
// keypad_pattern
//   Combinational digit -> keypad line vector lookup.
//   Ports:
//     digit   in  4  BCD digit to look up
//     pattern out 7  line vector {g,f,e,d,c,b,a}; all zero for illegal digits
//     legal   out 1  high when digit is 0..9
module keypad_pattern
  import keypad_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern,
  output logic       legal
);

  always_comb begin
    pattern = 7'b0;
    case (digit)
      4'd0:    pattern = PAT_0;
      4'd1:    pattern = PAT_1;
      4'd2:    pattern = PAT_2;
      4'd3:    pattern = PAT_3;
      4'd4:    pattern = PAT_4;
      4'd5:    pattern = PAT_5;
      4'd6:    pattern = PAT_6;
      4'd7:    pattern = PAT_7;
      4'd8:    pattern = PAT_8;
      4'd9:    pattern = PAT_9;
      default: pattern = 7'b0;
    endcase
  end

  assign legal = (digit <= ERR_DIGIT);

endmodule

// File: rtl/keypad_press_gen.sv
// keypad_press_gen
//   Keypress emulator for a 3x4 phone keypad. A BCD digit accepted over a
//   valid/ready handshake is turned into a timed column+row press followed
//   by an all-low release gap.
//   Optional feature: define KEYPAD_BOUNCE_EN to make the first
//   BOUNCE_CYCLES press cycles chatter (pattern, low, pattern, ...).
//   Ports:
//     clock      in   1  rising-edge clock
//     reset_n    in   1  synchronous active-low reset
//     in_valid   in   1  digit offered
//     in_number  in   4  digit to press (0..9 legal)
//     in_ready   out  1  high only while IDLE
//     err        out  1  one-cycle pulse after an illegal digit is accepted
//     busy       out  1  high during PRESS and GAP
//     a,b,c      out  1  registered column lines
//     d,e,f,g    out  1  registered row lines
module keypad_press_gen
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int BOUNCE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] in_number,
  output logic       in_ready,
  output logic       err,
  output logic       busy,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

`ifdef KEYPAD_BOUNCE_EN
  localparam bit BOUNCE_ACTIVE = 1'b1;
`else
  localparam bit BOUNCE_ACTIVE = 1'b0;
`endif

  // Timer is loaded with (length - 1) on state entry and leaves the state at 0.
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LEN = CNT_W'(BOUNCE_ACTIVE ? BOUNCE_CYCLES : 0);

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] timer_reg,   timer_next;
  logic [6:0]       pattern_reg, pattern_next;
  logic [6:0]       lines_reg,   lines_next;
  logic             err_reg,     err_next;

  logic [6:0]       dig_pattern;
  logic             dig_legal;
  logic [CNT_W-1:0] press_idx;

  keypad_pattern u_pattern (
    .digit   (in_number),
    .pattern (dig_pattern),
    .legal   (dig_legal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      pattern_reg <= '0;
      lines_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      pattern_reg <= pattern_next;
      lines_reg   <= lines_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    pattern_next = pattern_reg;
    err_next     = 1'b0;
    lines_next   = 7'b0;
    press_idx    = '0;

    case (state_reg)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is a transfer.
        if (in_valid) begin
          if (dig_legal) begin
            state_next   = PRESS;
            timer_next   = PRESS_LOAD;
            pattern_next = dig_pattern;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      PRESS: begin
        if (timer_reg == '0) begin
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
            timer_next = '0;
          end else begin
            state_next = GAP;
            timer_next = GAP_LOAD;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      GAP: begin
        if (timer_reg == '0) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Lines are registered, so they are derived from the state being entered.
    // press_idx counts press cycles from 0; odd cycles inside the bounce
    // window are forced low.
    if (state_next == PRESS) begin
      press_idx  = PRESS_LOAD - timer_next;
      lines_next = pattern_next;
      if ((press_idx < BOUNCE_LEN) && press_idx[0]) begin
        lines_next = 7'b0;
      end
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign err      = err_reg;

  assign a = lines_reg[0];
  assign b = lines_reg[1];
  assign c = lines_reg[2];
  assign d = lines_reg[3];
  assign e = lines_reg[4];
  assign f = lines_reg[5];
  assign g = lines_reg[6];

endmodule

// File: tb/tb_keypad_press_gen.sv
// tb_keypad_press_gen
//   Self-checking bench for keypad_press_gen. A cycle-indexed model (time of
//   last accept + arithmetic on the press/gap lengths) predicts every output
//   after every edge; directed scenarios add literal expectations, then a
//   randomized phase exercises handshakes, illegal digits and resets.
module tb_keypad_press_gen;

  localparam int P = 4;
  localparam int G = 2;
  localparam int B = 3;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BL = B;
  localparam logic [3:0] BOUNCE_SEQ = 4'b1101;  // k=0..3 -> 1,0,1,1
`else
  localparam int BL = 0;
  localparam logic [3:0] BOUNCE_SEQ = 4'b1111;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_number = 4'd0;
  logic       in_ready, err, busy;
  logic       a, b, c, d, e, f, g;

  keypad_press_gen #(
    .PRESS_CYCLES  (P),
    .GAP_CYCLES    (G),
    .BOUNCE_CYCLES (B),
    .CNT_W         (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_number (in_number),
    .in_ready  (in_ready),
    .err       (err),
    .busy      (busy),
    .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g)
  );

  always #5 clock = ~clock;

  // Model state: edge counter, edge of last legal accept, its pattern.
  int         n = 0;
  int         acc_t = -1000;
  logic [6:0] acc_pat = 7'b0;
  logic       err_exp = 1'b0;

  int total = 0;
  int passed = 0;

  // Keypad geometry: digits 1..9 fill a 3x3 grid row-major; 0 sits under 8.
  function automatic logic [6:0] key_lines(input int dg);
    int col, row;
    if (dg == 0) begin
      col = 1; row = 3;
    end else begin
      col = (dg - 1) % 3; row = (dg - 1) / 3;
    end
    return 7'((1 << col) | (1 << (3 + row)));
  endfunction

  // Loopback decoder: returns -1 unless exactly one column and one row are high.
  function automatic int decode(input logic [6:0] l);
    int col, row, nc, nr;
    col = 0; row = 0; nc = 0; nr = 0;
    for (int i = 0; i < 3; i++) if (l[i]) begin col = i; nc++; end
    for (int i = 0; i < 4; i++) if (l[3+i]) begin row = i; nr++; end
    if (nc != 1 || nr != 1) return -1;
    if (row == 3) return (col == 1) ? 0 : -1;
    return row * 3 + col + 1;
  endfunction

  function automatic logic [6:0] exp_lines();
    int k;
    k = n - acc_t;
    if (k >= 0 && k < P && !(k < BL && (k % 2) == 1)) return acc_pat;
    return 7'b0;
  endfunction

  function automatic logic exp_ready();
    return (n >= acc_t + P + G);
  endfunction

  function automatic logic [6:0] dut_lines();
    return {g, f, e, d, c, b, a};
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s edge %0d: got %0h expected %0h", name, n, act, expv);
  endtask

  // One clock edge: update the model with the inputs seen at the edge, then
  // compare every output just after it.
  task automatic step();
    logic ready_before;
    @(posedge clock);
    ready_before = exp_ready();
    n++;
    err_exp = 1'b0;
    if (!reset_n) begin
      acc_t = -1000;
    end else if (in_valid && ready_before) begin
      if (in_number <= 4'd9) begin
        acc_t   = n;
        acc_pat = key_lines(int'(in_number));
        $display("edge %0d: accept digit %0d", n, in_number);
      end else begin
        err_exp = 1'b1;
        $display("edge %0d: reject digit %0d", n, in_number);
      end
    end
    #1;
    check("lines", int'(dut_lines()), int'(exp_lines()));
    check("in_ready", int'(in_ready), int'(exp_ready()));
    check("busy", int'(busy), int'(!exp_ready()));
    check("err", int'(err), int'(err_exp));
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic press(input int dg);
    wait_ready();
    in_valid = 1'b1;
    in_number = 4'(dg);
    step();
    in_valid = 1'b0;
  endtask

  logic [3:0] seq;

  initial begin
    // Reset state
    reset_n = 1'b0;
    step();
    step();
    check("rst_lines_lit", int'(dut_lines()), 0);
    check("rst_ready_lit", int'(in_ready), 1);
    reset_n = 1'b1;
    step();

    // Digit 5 timing: lines after edges T..T+3, gap T+4..T+5, ready after T+6
    press(5);
    check("d5_k0_lit", int'(dut_lines()), 7'b0010010);
    step(); step(); step();
    check("d5_k3_lit", int'(dut_lines()), 7'b0010010);
    step();
    check("d5_gap0_lit", int'(dut_lines()), 0);
    check("d5_gap_busy_lit", int'(busy), 1);
    step();
    check("d5_gap1_ready_lit", int'(in_ready), 0);
    step();
    check("d5_idle_ready_lit", int'(in_ready), 1);

    // Digit 0 and sweep 1..9 through the loopback decoder
    press(0);
    check("d0_lit", int'(dut_lines()), 7'b1000010);
    check("d0_loop", decode(dut_lines()), 0);
    for (int dg = 1; dg <= 9; dg++) begin
      press(dg);
      check("sweep_loop", decode(dut_lines()), dg);
    end

    // Illegal 12, then 3 on the very next edge
    wait_ready();
    in_valid = 1'b1;
    in_number = 4'd12;
    step();
    check("err12_lit", int'(err), 1);
    check("err12_ready_lit", int'(in_ready), 1);
    check("err12_lines_lit", int'(dut_lines()), 0);
    in_number = 4'd3;
    step();
    in_valid = 1'b0;
    check("after_err_d3_lit", int'(dut_lines()), 7'b0001100);
    check("after_err_noerr_lit", int'(err), 0);

    // Back-to-back 7 then 8 with in_valid held
    wait_ready();
    in_valid = 1'b1;
    in_number = 4'd7;
    step();
    in_number = 4'd8;
    for (int i = 0; i < 6; i++) step();
    check("b2b_gap_lit", int'(dut_lines()), 0);
    step();
    check("b2b_d8_lit", int'(dut_lines()), 7'b0100010);
    in_valid = 1'b0;

    // Reset during press cycle 2
    press(4);
    step();
    reset_n = 1'b0;
    step();
    check("midrst_lines_lit", int'(dut_lines()), 0);
    check("midrst_ready_lit", int'(in_ready), 1);
    check("midrst_busy_lit", int'(busy), 0);
    reset_n = 1'b1;

    // Press shape of digit 9 (chatter when the bounce build is selected)
    press(9);
    seq[0] = c & f;
    for (int k = 1; k < 4; k++) begin
      step();
      seq[k] = c & f;
    end
    check("d9_seq_lit", int'(seq), int'(BOUNCE_SEQ));
    step();
    check("d9_gap_lit", int'(dut_lines()), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset_n  = ($urandom_range(0, 79) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_number = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      step();
    end
    reset_n = 1'b1;
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
